// File: rtl/aes_i2c_pkg.sv
// Shared definitions for the I2C-fed AES command path.
// Holds the frame width and field offsets, command opcodes, status bit
// indices and the dispatcher FSM state encoding.
package aes_i2c_pkg;

  localparam int FRAME_W = 264;
  localparam int CMD_MSB = 263;
  localparam int KEY_MSB = 255;
  localparam int BLK_MSB = 127;

  localparam logic [7:0] CMD_CLEAR    = 8'h00;
  localparam logic [7:0] CMD_LOAD_KEY = 8'h01;
  localparam logic [7:0] CMD_LOAD_ENC = 8'h02;
  localparam logic [7:0] CMD_ENC      = 8'h03;
  localparam logic [7:0] CMD_DEC      = 8'h04;

  localparam int ST_KEY_LOADED = 0;
  localparam int ST_BAD_CMD    = 1;
  localparam int ST_NO_KEY     = 2;
  localparam int ST_TIMEOUT    = 3;
  localparam int ST_OVERRUN    = 4;
  localparam int ST_LAST_DEC   = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ISSUE  = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/aes_watchdog.sv
// Saturating cycle counter with clear/enable and a terminal flag.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : forces the count to zero (has priority over enable)
//   enable     : advance the count by one, stopping at TIMEOUT_CYCLES-1
//   terminal   : high while the count equals TIMEOUT_CYCLES-1
module aes_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/aes_frame_dispatcher.sv
// Captures completed 33-byte I2C frames, decodes the command byte, owns the
// AES-128 key register and issues key/block requests to the AES core.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   frame_data, frame_done      : frame from the I2C slave and its done level
//   aes_req_valid/ready         : request handshake to the AES core
//   aes_key, aes_block, aes_decrypt : request payload, stable while valid
//   aes_rsp_valid, aes_rsp_data : single-cycle response from the core
//   result_data, result_valid   : last successful result for readback
//   busy                        : FSM not idle
//   status                      : {2'b0, last_dec, overrun, timeout, no_key, bad_cmd, key_loaded}
module aes_frame_dispatcher
  import aes_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_done,
  output logic               aes_req_valid,
  input  logic               aes_req_ready,
  output logic [127:0]       aes_key,
  output logic [127:0]       aes_block,
  output logic               aes_decrypt,
  input  logic               aes_rsp_valid,
  input  logic [127:0]       aes_rsp_data,
  output logic [127:0]       result_data,
  output logic               result_valid,
  output logic               busy,
  output logic [7:0]         status
);

  state_t state, state_next;

  logic               frame_done_p1;
  logic [FRAME_W-1:0] frame_q;
  logic [127:0]       key_reg;
  logic               key_loaded, bad_cmd, no_key, timeout, overrun, last_dec;
  logic               timer_term;

  logic         frame_rise;
  logic [7:0]   cmd;
  logic [127:0] frame_key, frame_blk;

  assign frame_rise = frame_done && !frame_done_p1;
  assign cmd        = frame_q[CMD_MSB -: 8];
  assign frame_key  = frame_q[KEY_MSB -: 128];
  assign frame_blk  = frame_q[BLK_MSB -: 128];

  // Timer is held cleared through ISSUE so it starts from zero on acceptance.
  aes_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == S_ISSUE),
    .enable   (state == S_WAIT),
    .terminal (timer_term)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (frame_rise) state_next = S_DECODE;
      S_DECODE: begin
        state_next = S_IDLE;
        if (cmd == CMD_LOAD_ENC) state_next = S_ISSUE;
        else if ((cmd == CMD_ENC || cmd == CMD_DEC) && key_loaded) state_next = S_ISSUE;
      end
      S_ISSUE:  if (aes_req_ready) state_next = S_WAIT;
      S_WAIT:   if (aes_rsp_valid || timer_term) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Frame capture, key register, request payload and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_p1 <= 1'b0;
      frame_q       <= '0;
      key_reg       <= '0;
      key_loaded    <= 1'b0;
      bad_cmd       <= 1'b0;
      no_key        <= 1'b0;
      timeout       <= 1'b0;
      overrun       <= 1'b0;
      last_dec      <= 1'b0;
      aes_key       <= '0;
      aes_block     <= '0;
      aes_decrypt   <= 1'b0;
      result_data   <= '0;
      result_valid  <= 1'b0;
    end else begin
      frame_done_p1 <= frame_done;
      case (state)
        S_IDLE: begin
          if (frame_rise) begin
            frame_q      <= frame_data;
            result_valid <= 1'b0;
          end
        end
        S_DECODE: begin
          case (cmd)
            CMD_CLEAR: begin
              bad_cmd <= 1'b0;
              no_key  <= 1'b0;
              timeout <= 1'b0;
              overrun <= 1'b0;
            end
            CMD_LOAD_KEY: begin
              key_reg    <= frame_key;
              key_loaded <= 1'b1;
            end
            CMD_LOAD_ENC: begin
              key_reg     <= frame_key;
              key_loaded  <= 1'b1;
              aes_key     <= frame_key;
              aes_block   <= frame_blk;
              aes_decrypt <= 1'b0;
            end
            CMD_ENC, CMD_DEC: begin
              if (key_loaded) begin
                aes_key     <= key_reg;
                aes_block   <= frame_blk;
                aes_decrypt <= (cmd == CMD_DEC);
              end else begin
                no_key <= 1'b1;
              end
            end
            default: bad_cmd <= 1'b1;
          endcase
        end
        S_WAIT: begin
          // A response in the terminal cycle wins over the timeout.
          if (aes_rsp_valid) begin
            result_data  <= aes_rsp_data;
            result_valid <= 1'b1;
            last_dec     <= aes_decrypt;
          end else if (timer_term) begin
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
      // Placed after the clear command so a drop in the same cycle still records.
      if (frame_rise && state != S_IDLE) overrun <= 1'b1;
    end
  end

  assign aes_req_valid = (state == S_ISSUE);
  assign busy          = (state != S_IDLE);
  assign status        = {2'b00, last_dec, overrun, timeout, no_key, bad_cmd, key_loaded};

endmodule

// File: doc/aes_frame_dispatcher.md
# aes_frame_dispatcher

Sits directly downstream of the I2C slave receiver. It captures each completed 33-byte I2C frame and decodes its command byte. It keeps the AES-128 key register and issues key and block requests to the AES core over a valid/ready handshake. It latches the 128-bit result and status for the readback path.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: max cycles to wait for a core response after the request is accepted; minimum 2.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- frame_data  in  264  frame from the I2C slave. Layout:
  - [263:256] command byte (first data byte).
  - [255:128] key, MSB-first.
  - [127:0] block, MSB-first.
- frame_done  in  1  level from the I2C slave; high from the end of the last byte until the stop condition.
- aes_req_valid  out  1  request to the AES core.
- aes_req_ready  in  1  core accepts the request.
- aes_key  out  128  key for the request.
- aes_block  out  128  block for the request.
- aes_decrypt  out  1  0 = encrypt, 1 = decrypt.
- aes_rsp_valid  in  1  single-cycle response strobe.
- aes_rsp_data  in  128  core result.
- result_data  out  128  last successful result.
- result_valid  out  1  result_data holds a result for the most recent accepted frame.
- busy  out  1  high in any state other than IDLE.
- status  out  8  status bits:
  - [0] key_loaded.
  - [1] bad_cmd, sticky.
  - [2] no_key, sticky.
  - [3] timeout, sticky.
  - [4] overrun, sticky.
  - [5] last_op_decrypt.
  - [7:6] always 0.

## Operation
- Commands:
  - 8'h00: clear status[4:1].
  - 8'h01: load key only.
  - 8'h02: load key, then encrypt the block.
  - 8'h03: encrypt with the stored key.
  - 8'h04: decrypt with the stored key.
  - Any other value sets bad_cmd.
- States:
  - IDLE: on a frame_done rise (frame_done high, registered copy low), register frame_data, clear result_valid, go to DECODE.
  - DECODE: act on the command.
    - 00/01/bad: perform the action, go to IDLE.
    - 03/04 with key_loaded=0: set no_key, go to IDLE.
    - 02/03/04 otherwise: go to ISSUE.
    - 01/02: write the key register and set key_loaded.
  - ISSUE: hold aes_req_valid=1 with aes_key/aes_block/aes_decrypt stable. On aes_req_valid&&aes_req_ready, clear the timer and go to WAIT.
  - WAIT: on aes_rsp_valid, latch aes_rsp_data into result_data, set result_valid, update last_op_decrypt, go to IDLE. If the timer reaches TIMEOUT_CYCLES-1 first, set timeout and go to IDLE; result_valid stays 0.
- A frame_done rise while busy is dropped: the frame is not captured and overrun is set.
- aes_rsp_valid is ignored outside WAIT.
- The key register and key_loaded change only on commands 01/02.
- A bad command or no_key does not alter the key, result_data or key_loaded.
- Reset values:
  - State IDLE.
  - Every output 0 (aes_key/aes_block/result_data all zero, status 8'h00).
  - Key register 0.
  - Registered frame_done copy 0.

## Timing
- Cycle numbering: t = first cycle frame_done is sampled high after being low.
  - t+1: state DECODE, busy=1.
  - t+2: aes_req_valid=1 for 02/03/04; status bits for 00/01/bad are visible and busy=0.
- Response at cycle r: result_valid=1 and result_data valid at r+1; busy=0 at r+1.
- aes_req_valid never deasserts before it is accepted. There is no request timeout in ISSUE; the core is guaranteed to eventually assert aes_req_ready.
- Simultaneous events:
  - aes_rsp_valid in the same cycle the timer reaches TIMEOUT_CYCLES-1: the response wins, timeout is not set.
  - A frame_done rise in the cycle the FSM returns to IDLE is an overrun.
- frame_done held high across several frames without falling produces one capture only.
- Reset mid-request: aes_req_valid drops in the next cycle. A late aes_rsp_valid is then ignored.
- The timer is log2(TIMEOUT_CYCLES) bits and saturates; it does not wrap.

## Structure
- Shared package aes_i2c_pkg:
  - Command opcodes.
  - Status bit indices.
  - Frame field offsets (CMD_MSB=263, KEY_MSB=255, BLK_MSB=127).
  - FSM state encodings.
  - Frame width 264.
- One sub-module, aes_watchdog: a clear/enable saturating counter with a terminal flag. It is parameterised by TIMEOUT_CYCLES and reusable for I2C bus-stall detection.

## Test plan
- Load then encrypt:
  - Stimulus: frame cmd 01, key 000102…0f. Then frame cmd 03, block 00112233445566778899aabbccddeeff. Core model responds 3 cycles after acceptance with 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: status=8'h01 after the first frame. result_valid=1 with that result_data after the second; status[5]=0.
- Stored-key check:
  - Stimulus: from reset, frame cmd 04.
  - Required: status=8'h04, no aes_req_valid. Then cmd 00 gives status=8'h00.
- Bad command:
  - Stimulus: frame cmd 8'h7f.
  - Required: status[1]=1, key and result_data unchanged, busy low at t+2.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, cmd 02, core never responds.
  - Required: busy falls 8 cycles after acceptance, status[3]=1, result_valid=0. Then aes_rsp_valid in IDLE is ignored.
- Overrun and backpressure:
  - Stimulus: aes_req_ready held low for 20 cycles. During that time frame_done falls and rises again.
  - Required: aes_req_valid and its payload stay stable, status[4]=1, the second frame is not processed.
- Reset mid-WAIT:
  - Stimulus: reset asserted for one cycle.
  - Required: all outputs zero on the next cycle; key_loaded=0.
